bin_search_ctrl: RTL
====================

// Module: bin_search_ctrl
// PURPOSE
//  Sequential initiator for the n-bit magnitude comparator: drives a trial operand into an external
//  comparator (port b side) and consumes its eq/gt/lt flags. Performs a binary search to locate the
//  comparator's hidden operand (port a side, e.g. a threshold or DAC code) in [0, 2^N-1].
//  Sits between control logic (start/done) and a comp instance. One probe per 1+CMP_LAT cycles.
// PARAMETERS
//  N        5  operand width; must match the attached comparator's n
//  CMP_LAT  0  cycles between trial change and valid cmp flags (0 = combinational comparator)
// PORTS
//  clk       in   1        rising-edge clock
//  rst_n     in   1        asynchronous, active-low reset
//  start     in   1        begin a search; sampled only in IDLE
//  cmp_eq    in   1        comparator flag: hidden operand == trial
//  cmp_gt    in   1        comparator flag: hidden operand >  trial
//  cmp_lt    in   1        comparator flag: hidden operand <  trial
//  trial     out  N        registered trial operand driven to the comparator
//  busy      out  1        high from the cycle after start until DONE is left
//  done      out  1        one-cycle pulse when the search ends
//  found     out  1        eq was seen; valid with done, held until next start
//  err       out  1        flags were not one-hot at a sample; valid with done, held
//  result    out  N        last trial sampled (== hidden operand when found); held
//  probes    out  $clog2(N+2)  number of samples taken in the last search; held
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; trial=0, busy=0, done=0, found=0, err=0, result=0, probes=0.
//  Internal bounds lo, hi are N+1 bits wide so hi-1/lo+1 cannot wrap; wait counter is 0..CMP_LAT.
//  States: IDLE -> (start) PROBE -> DONE -> IDLE.
//  IDLE: start=1 -> lo=0, hi=2^N-1, trial=(2^N-1)>>1, probes=0, found=0, err=0, wait=0; go PROBE.
//  PROBE: if wait<CMP_LAT, increment wait; flags ignored. Else sample flags, probes+=1, result=trial:
//   - flags not exactly one-hot -> err=1, go DONE.
//   - eq -> found=1, go DONE.
//   - gt -> lo'=trial+1 ; lt -> hi'=trial-1 ; if lo'>hi' go DONE (found=0),
//     else trial=lo'+((hi'-lo')>>1), wait=0, stay PROBE.
//  DONE: done=1 for exactly this cycle; busy=0 next cycle; go IDLE. trial holds its last value.
//  busy=1 in PROBE and DONE states. start while not IDLE is ignored (no restart, no queueing).
//  Worst case N+1 samples (e.g. hidden operand = 2^N-1); probes never exceeds N+1.
//  start and done in the same cycle: start is ignored (state is DONE); it is accepted next cycle in IDLE.
//  Reset asserted mid-search: immediate return to IDLE with reset values; no done pulse.
//  Flags are sampled only on the sampling cycle; changes during wait cycles have no effect.
// TESTING
//  N=5,CMP_LAT=0, hidden=19, start -> trials 15,23,19; done at 3rd sample, found=1, result=19, probes=3.
//  N=5, hidden=31 -> trials 15,23,27,29,30,31; found=1, probes=6 (N+1 worst case).
//  N=5, hidden=0 -> trials 15,7,3,1,0; found=1, result=0, probes=5; no underflow of hi.
//  N=5, model forces gt=1,eq=0 always -> trials 15..31 as above, then done with found=0, err=0, result=31.
//  N=5, CMP_LAT=2, hidden=19 -> each trial held 3 cycles, done 9 cycles after PROBE entry, result=19.
//  Flags eq=gt=1 at 1st sample -> done, err=1, found=0, probes=1; rst_n pulse mid-search -> all outputs 0, IDLE.

Source files
------------

// File: rtl/bin_search_ctrl_if.sv
// Bus between bin_search_ctrl and its surroundings: the start/done control side
// and the trial/flag side of the attached magnitude comparator.
interface bin_search_ctrl_if #(
  parameter int N = 5
);
  localparam int PW = $clog2(N + 2);

  // start is a level sampled only while the controller is idle; done is a
  // one-cycle pulse, and found/err/result/probes are valid with it and held
  // until the next accepted start. There is no back-pressure on either side.
  logic          start;
  logic          busy;
  logic          done;
  logic          found;
  logic          err;
  logic [N-1:0]  result;
  logic [PW-1:0] probes;
  logic [N-1:0]  trial;
  logic          cmp_eq;
  logic          cmp_gt;
  logic          cmp_lt;

  modport master (
    input  start, cmp_eq, cmp_gt, cmp_lt,
    output busy, done, found, err, result, probes, trial
  );

  modport slave (
    output start, cmp_eq, cmp_gt, cmp_lt,
    input  busy, done, found, err, result, probes, trial
  );
endinterface

// File: rtl/bin_search_ctrl.sv
// Binary-search initiator: drives trial operands into an external comparator and
// narrows [lo, hi] until the comparator's hidden operand is found or ruled out.
module bin_search_ctrl #(
  parameter int N       = 5,
  parameter int CMP_LAT = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  bin_search_ctrl_if.master bus,
  output logic [1:0]        o_dbg_state
);
  localparam int PW = $clog2(N + 2);
  localparam int WW = (CMP_LAT > 0) ? $clog2(CMP_LAT + 1) : 1;
  localparam logic [WW-1:0] LAT_V = WW'(CMP_LAT);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_PROBE = 2'd1, S_DONE = 2'd2} state_t;

  state_t        r_state, w_state_n;
  logic [N:0]    r_lo, w_lo_n, r_hi, w_hi_n;
  logic [N-1:0]  r_trial, w_trial_n, r_result, w_result_n;
  logic [WW-1:0] r_wait, w_wait_n;
  logic [PW-1:0] r_probes, w_probes_n;
  logic          r_found, w_found_n, r_err, w_err_n;

  logic [N:0]    w_lo_up, w_hi_dn, w_mid_gt, w_mid_lt;
  logic          w_onehot;

  // Bounds carry an extra bit; the search terminates when the trial sits on the
  // bound being moved, so the narrowed range is only computed when non-empty.
  assign w_lo_up  = {1'b0, r_trial} + (N+1)'(1);
  assign w_hi_dn  = {1'b0, r_trial} - (N+1)'(1);
  assign w_mid_gt = w_lo_up + ((r_hi - w_lo_up) >> 1);
  assign w_mid_lt = r_lo + ((w_hi_dn - r_lo) >> 1);
  assign w_onehot = $onehot({bus.cmp_eq, bus.cmp_gt, bus.cmp_lt});

  always_comb begin
    w_state_n  = r_state;
    w_lo_n     = r_lo;
    w_hi_n     = r_hi;
    w_trial_n  = r_trial;
    w_wait_n   = r_wait;
    w_found_n  = r_found;
    w_err_n    = r_err;
    w_result_n = r_result;
    w_probes_n = r_probes;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_lo_n     = '0;
          w_hi_n     = {1'b0, {N{1'b1}}};
          w_trial_n  = {N{1'b1}} >> 1;
          w_probes_n = '0;
          w_found_n  = 1'b0;
          w_err_n    = 1'b0;
          w_wait_n   = '0;
          w_state_n  = S_PROBE;
        end
      end
      S_PROBE: begin
        if (r_wait != LAT_V) begin
          w_wait_n = r_wait + WW'(1);
        end else begin
          w_probes_n = r_probes + PW'(1);
          w_result_n = r_trial;
          w_wait_n   = '0;
          if (!w_onehot) begin
            w_err_n   = 1'b1;
            w_state_n = S_DONE;
          end else if (bus.cmp_eq) begin
            w_found_n = 1'b1;
            w_state_n = S_DONE;
          end else if (bus.cmp_gt) begin
            if ({1'b0, r_trial} == r_hi) begin
              w_state_n = S_DONE;
            end else begin
              w_lo_n    = w_lo_up;
              w_trial_n = w_mid_gt[N-1:0];
            end
          end else begin
            if ({1'b0, r_trial} == r_lo) begin
              w_state_n = S_DONE;
            end else begin
              w_hi_n    = w_hi_dn;
              w_trial_n = w_mid_lt[N-1:0];
            end
          end
        end
      end
      S_DONE:  w_state_n = S_IDLE;
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_lo     <= '0;
      r_hi     <= '0;
      r_trial  <= '0;
      r_wait   <= '0;
      r_found  <= 1'b0;
      r_err    <= 1'b0;
      r_result <= '0;
      r_probes <= '0;
    end else begin
      r_state  <= w_state_n;
      r_lo     <= w_lo_n;
      r_hi     <= w_hi_n;
      r_trial  <= w_trial_n;
      r_wait   <= w_wait_n;
      r_found  <= w_found_n;
      r_err    <= w_err_n;
      r_result <= w_result_n;
      r_probes <= w_probes_n;
    end
  end

  assign bus.trial   = r_trial;
  assign bus.busy    = (r_state != S_IDLE);
  assign bus.done    = (r_state == S_DONE);
  assign bus.found   = r_found;
  assign bus.err     = r_err;
  assign bus.result  = r_result;
  assign bus.probes  = r_probes;
  assign o_dbg_state = r_state;
endmodule
